plx_lbus_slave: RTL and testbench
=================================

# plx_lbus_slave

Local-bus slave front end for the 5i20's PLX 9030 target interface. Sits directly upstream of the I/O port register file. Decodes ADS/LW_R/BLAST cycles into single-cycle register read/write strobes with a latched, burst-incrementing word address. Drives the active-low READY handshake back to the PLX chip and the LAD output-enable for reads.

## Interface
- WAIT_STATES, 1, data-phase wait cycles inserted before READY asserts (0..7)
- AW, 7, word-address width (LAD[AW+1:2])
- LClk  in  1  local bus clock; all state changes on rising edge
- clear_n  in  1  reset, synchronous, active-low
- ADS  in  1  address strobe, active-low, one LClk wide
- LW_R  in  1  1 = write, 0 = read; sampled with ADS
- BLAST  in  1  burst-last, active-low, marks final data phase
- CS0  in  1  chip select for this space, active-high, sampled with ADS
- LAD_in  in  32  LAD as seen by the FPGA (address at ADS, write data in data phase)
- LBE  in  4  byte enables, active-low, passed through per data phase
- READY  out  1  active-low ready to PLX; 1 at reset
- addr  out  AW  current word address; 0 at reset
- wr_strobe  out  1  one-cycle write pulse to register file; 0 at reset
- rd_strobe  out  1  one-cycle read-capture pulse; 0 at reset
- fast_read  out  1  read in progress, drives LAD output-enable and read decode; 0 at reset
- be  out  4  active-high byte enables (~LBE) registered with each strobe; 0 at reset
- wdata  out  32  LAD_in registered with wr_strobe; 0 at reset

## Operation
- FSM states: IDLE, WAIT, XFER, NEXT.
- IDLE: on ADS=0 and CS0=1, latch addr←LAD_in[AW+1:2] and dir←LW_R. Go to WAIT when WAIT_STATES>0, else XFER. ADS with CS0=0 is ignored.
- WAIT: count down WAIT_STATES cycles. fast_read=1 throughout for reads, so data is settled before READY.
- XFER: READY=0 for exactly one cycle.
  - Write: wr_strobe=1 with wdata/be captured that cycle.
  - Read: rd_strobe=1.
  - BLAST=0 sampled in XFER → IDLE. Otherwise → NEXT.
- NEXT: addr←addr+1, wrapping modulo 2^AW (all-ones → 0). Re-enter WAIT (count reloaded) or XFER.
- fast_read=1 from the cycle after ADS (read, CS0=1) through the XFER cycle of the last phase. 0 otherwise.
- ADS=0 in any state other than IDLE is a protocol error. It is ignored; the current cycle completes.
- clear_n=0 at any point, including mid-burst: next edge forces IDLE and all outputs to reset values. No strobe is emitted on the reset edge.

## Timing
- Single read, WAIT_STATES=W: ADS at edge 0. fast_read=1 from edge 1. READY=0 and rd_strobe=1 at edge 1+W.
- Single write: same timing with wr_strobe.
- Burst phase spacing: W+2 cycles (XFER, NEXT, W waits).
- Back-to-back cycles: ADS is accepted the cycle after a final XFER (IDLE is entered that edge).
- All outputs are registered. No combinational path from inputs to outputs.

## Structure
- Shared package holds:
  - the state encoding (IDLE=2'd0, WAIT=2'd1, XFER=2'd2, NEXT=2'd3);
  - default AW;
  - the LBE→be inversion helper.
- No sub-module. The wait counter is an inline 3-bit down-counter.

## Test plan
- Reset: clear_n=0 for 2 cycles mid-burst → READY=1, strobes 0, addr=0, state IDLE on the next edge.
- Single write, W=1: ADS=0, LW_R=1, CS0=1, LAD_in=0x0000_0014, then data 0xA5A5_1234, LBE=4'b0000, BLAST=0.
  - Expect addr=5.
  - Expect wr_strobe and READY=0 at edge 2, wdata=0xA5A5_1234, be=4'hF.
- Single read, W=0: ADS at addr 0x08 → fast_read=1 and rd_strobe/READY=0 at edge 1, addr=2; fast_read=0 at edge 2.
- Burst write, W=0: 4 phases from addr 0x7E (AW=7), BLAST=0 on 4th.
  - Expect addr sequence 126, 127, 0, 1.
  - Expect 4 wr_strobes spaced 2 cycles apart.
- CS0=0 with ADS → no state change, no strobe, READY stays 1.
- Stray ADS during WAIT of a read → ignored; original addr is kept and exactly one rd_strobe is issued.

Source files
------------

// File: rtl/plx_lbus_slave_pkg.sv
// Shared definitions for the PLX 9030 local-bus slave front end:
// FSM state encoding, default address width and the byte-enable helper.
package plx_lbus_slave_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        XFER = 2'd2,
        NEXT = 2'd3
    } state_t;

    localparam int DEFAULT_AW = 7;

    // LBE on the PLX side is active-low; the register file wants active-high.
    function automatic logic [3:0] lbe_to_be(input logic [3:0] lbe);
        return ~lbe;
    endfunction

endpackage

// File: rtl/plx_lbus_slave_if.sv
// Local-bus signal bundle between the PLX 9030 (master side) and the
// slave front end, plus the register-file strobes the slave produces.
interface plx_lbus_slave_if #(
    parameter int AW = plx_lbus_slave_pkg::DEFAULT_AW
) ();

    logic          ADS;
    logic          LW_R;
    logic          BLAST;
    logic          CS0;
    logic [31:0]   LAD_in;
    logic [3:0]    LBE;

    logic          READY;
    logic [AW-1:0] addr;
    logic          wr_strobe;
    logic          rd_strobe;
    logic          fast_read;
    logic [3:0]    be;
    logic [31:0]   wdata;

    modport slave (
        input  ADS, LW_R, BLAST, CS0, LAD_in, LBE,
        output READY, addr, wr_strobe, rd_strobe, fast_read, be, wdata
    );

    modport master (
        output ADS, LW_R, BLAST, CS0, LAD_in, LBE,
        input  READY, addr, wr_strobe, rd_strobe, fast_read, be, wdata
    );

endinterface

// File: rtl/plx_lbus_slave.sv
// PLX 9030 local-bus slave: turns ADS/LW_R/BLAST cycles into single-cycle
// register strobes with a latched, burst-incrementing word address and a
// registered active-low READY handshake. Every output is a flop.
module plx_lbus_slave
    import plx_lbus_slave_pkg::*;
#(
    parameter int WAIT_STATES = 1,
    parameter int AW          = DEFAULT_AW
) (
    input  logic            LClk,
    input  logic            clear_n,
    plx_lbus_slave_if.slave bus
);

    localparam bit         HAS_WAIT  = (WAIT_STATES > 0);
    localparam logic [2:0] WAIT_LOAD = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

    state_t     state;
    logic       dir;
    logic [2:0] wait_cnt;
    logic       go_xfer;
    logic       go_write;

    // Decide whether the coming edge enters XFER, and in which direction.
    always_comb begin
        go_xfer  = 1'b0;
        go_write = dir;
        case (state)
            IDLE: begin
                if (!bus.ADS && bus.CS0 && !HAS_WAIT) begin
                    go_xfer  = 1'b1;
                    go_write = bus.LW_R;
                end
            end
            WAIT: begin
                if (wait_cnt == 3'd0) begin
                    go_xfer = 1'b1;
                end
            end
            NEXT: begin
                if (!HAS_WAIT) begin
                    go_xfer = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    // Bus FSM with registered handshake, address and register-file outputs.
    always_ff @(posedge LClk) begin
        if (!clear_n) begin
            state         <= IDLE;
            dir           <= 1'b0;
            wait_cnt      <= 3'd0;
            bus.READY     <= 1'b1;
            bus.addr      <= '0;
            bus.wr_strobe <= 1'b0;
            bus.rd_strobe <= 1'b0;
            bus.fast_read <= 1'b0;
            bus.be        <= 4'h0;
            bus.wdata     <= 32'h0;
        end else begin
            bus.READY     <= 1'b1;
            bus.wr_strobe <= 1'b0;
            bus.rd_strobe <= 1'b0;

            case (state)
                IDLE: begin
                    if (!bus.ADS && bus.CS0) begin
                        bus.addr      <= bus.LAD_in[AW+1:2];
                        dir           <= bus.LW_R;
                        bus.fast_read <= !bus.LW_R;
                        wait_cnt      <= WAIT_LOAD;
                        state         <= HAS_WAIT ? WAIT : XFER;
                    end
                end
                WAIT: begin
                    if (wait_cnt == 3'd0) begin
                        state <= XFER;
                    end else begin
                        wait_cnt <= wait_cnt - 3'd1;
                    end
                end
                XFER: begin
                    if (!bus.BLAST) begin
                        state         <= IDLE;
                        bus.fast_read <= 1'b0;
                    end else begin
                        state    <= NEXT;
                        bus.addr <= bus.addr + AW'(1);
                    end
                end
                NEXT: begin
                    wait_cnt <= WAIT_LOAD;
                    state    <= HAS_WAIT ? WAIT : XFER;
                end
                default: begin
                    state <= IDLE;
                end
            endcase

            if (go_xfer) begin
                bus.READY <= 1'b0;
                bus.be    <= lbe_to_be(bus.LBE);
                if (go_write) begin
                    bus.wr_strobe <= 1'b1;
                    bus.wdata     <= bus.LAD_in;
                end else begin
                    bus.rd_strobe <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_plx_lbus_slave.sv
// Self-checking bench for plx_lbus_slave: three instances (0, 1 and 3 wait
// states) share one stimulus source; a transaction-level model predicts the
// strobe schedule, addresses and captured data of each burst.
module tb_plx_lbus_slave;

    localparam int TB_AW = 7;

    logic        clk = 1'b0;
    logic        clear_n;
    logic        ads;
    logic        lw_r;
    logic        blast;
    logic        cs0;
    logic [31:0] lad;
    logic [3:0]  lbe;
    int          sel;

    int checks = 0;
    int errors = 0;

    logic             obs_ready[3];
    logic [TB_AW-1:0] obs_addr[3];
    logic             obs_wr[3];
    logic             obs_rd[3];
    logic             obs_fr[3];
    logic [3:0]       obs_be[3];
    logic [31:0]      obs_wdata[3];

    logic [TB_AW-1:0] m_addr[3];
    logic [3:0]       m_be[3];
    logic [31:0]      m_wdata[3];

    always #5 clk = ~clk;

    plx_lbus_slave_if #(.AW(TB_AW)) bus [3] ();

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int W = (g == 0) ? 0 : ((g == 1) ? 1 : 3);

        plx_lbus_slave #(.WAIT_STATES(W), .AW(TB_AW)) dut (
            .LClk    (clk),
            .clear_n (clear_n),
            .bus     (bus[g])
        );

        assign bus[g].ADS    = (sel == g) ? ads : 1'b1;
        assign bus[g].CS0    = (sel == g) ? cs0 : 1'b0;
        assign bus[g].LW_R   = lw_r;
        assign bus[g].BLAST  = blast;
        assign bus[g].LAD_in = lad;
        assign bus[g].LBE    = lbe;

        assign obs_ready[g] = bus[g].READY;
        assign obs_addr[g]  = bus[g].addr;
        assign obs_wr[g]    = bus[g].wr_strobe;
        assign obs_rd[g]    = bus[g].rd_strobe;
        assign obs_fr[g]    = bus[g].fast_read;
        assign obs_be[g]    = bus[g].be;
        assign obs_wdata[g] = bus[g].wdata;
    end

    function automatic int wait_of(input int s);
        return (s == 0) ? 0 : ((s == 1) ? 1 : 3);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic checkReset(input int s);
        checkOutput($sformatf("rst_ready[%0d]", s), 32'(obs_ready[s]), 32'd1);
        checkOutput($sformatf("rst_addr[%0d]", s),  32'(obs_addr[s]),  32'd0);
        checkOutput($sformatf("rst_wr[%0d]", s),    32'(obs_wr[s]),    32'd0);
        checkOutput($sformatf("rst_rd[%0d]", s),    32'(obs_rd[s]),    32'd0);
        checkOutput($sformatf("rst_fr[%0d]", s),    32'(obs_fr[s]),    32'd0);
        checkOutput($sformatf("rst_be[%0d]", s),    32'(obs_be[s]),    32'd0);
        checkOutput($sformatf("rst_wdata[%0d]", s), obs_wdata[s],      32'd0);
    endtask

    task automatic clearModel();
        for (int i = 0; i < 3; i++) begin
            m_addr[i]  = '0;
            m_be[i]    = 4'h0;
            m_wdata[i] = 32'h0;
        end
    endtask

    // One local-bus cycle: ADS, then data phases until BLAST, checked per edge.
    task automatic applyStimulus(input int s, input bit wr, input bit cs, input logic [31:0] lad_addr,
                                 input int n, input bit stray, input logic [31:0] d0, input logic [3:0] b0);
        int               w;
        int               se[$];
        int               last;
        int               pd;
        int               pb;
        int               phase;
        bit               strobe;
        logic [31:0]      lad_prev;
        logic [3:0]       lbe_prev;
        logic [TB_AW-1:0] waddr;
        logic [TB_AW-1:0] prev_addr;

        w         = wait_of(s);
        waddr     = lad_addr[TB_AW+1:2];
        prev_addr = m_addr[s];
        for (int i = 0; i < n; i++) se.push_back(1 + w + i * (w + 2));
        last = cs ? se[n-1] : 3;

        sel   = s;
        ads   = 1'b0;
        lw_r  = wr;
        cs0   = cs;
        lad   = lad_addr;
        lbe   = 4'($urandom);
        blast = 1'b1;

        for (int e = 1; e <= last + 2; e++) begin
            lad_prev = lad;
            lbe_prev = lbe;
            @(posedge clk);
            #1;

            strobe = 1'b0;
            phase  = 0;
            if (cs) begin
                for (int i = 0; i < n; i++) begin
                    if (se[i] == e) begin
                        strobe = 1'b1;
                        phase  = i;
                    end
                end
                if (e == 1) m_addr[s] = waddr;
            end
            if (strobe) begin
                m_addr[s] = TB_AW'((32'(waddr) + 32'(phase)) % (1 << TB_AW));
                m_be[s]   = ~lbe_prev;
                if (wr) m_wdata[s] = lad_prev;
            end
            if (!cs) m_addr[s] = prev_addr;

            checkOutput($sformatf("ready[%0d]@%0d", s, e), 32'(obs_ready[s]), 32'(!strobe));
            checkOutput($sformatf("wr[%0d]@%0d", s, e),    32'(obs_wr[s]),    32'(strobe && wr));
            checkOutput($sformatf("rd[%0d]@%0d", s, e),    32'(obs_rd[s]),    32'(strobe && !wr));
            checkOutput($sformatf("fr[%0d]@%0d", s, e),    32'(obs_fr[s]),    32'(cs && !wr && e <= last));
            if (e == 1 || strobe || e > last || !cs)
                checkOutput($sformatf("addr[%0d]@%0d", s, e), 32'(obs_addr[s]), 32'(m_addr[s]));
            checkOutput($sformatf("be[%0d]@%0d", s, e),    32'(obs_be[s]),    32'(m_be[s]));
            checkOutput($sformatf("wdata[%0d]@%0d", s, e), obs_wdata[s],      m_wdata[s]);

            ads = 1'b1;
            pd  = 0;
            pb  = 0;
            foreach (se[i]) begin
                if (se[i] <= e) pd++;
                if (se[i] < e)  pb++;
            end
            lad   = (pd == 0) ? d0 : $urandom;
            lbe   = (pd == 0) ? b0 : 4'($urandom);
            blast = (cs && pb == n - 1) ? 1'b0 : 1'b1;
            if (stray && e == 1) begin
                ads  = 1'b0;
                cs0  = 1'b1;
                lad  = lad_addr ^ 32'h0000_0154;
            end
        end
        ads   = 1'b1;
        blast = 1'b1;
        cs0   = 1'b0;
    endtask

    initial begin
        int          rs;
        bit          rwr;
        int          rn;

        clear_n = 1'b0;
        ads     = 1'b1;
        lw_r    = 1'b0;
        blast   = 1'b1;
        cs0     = 1'b0;
        lad     = 32'h0;
        lbe     = 4'hF;
        sel     = 0;
        clearModel();

        repeat (2) @(posedge clk);
        #1;
        for (int s = 0; s < 3; s++) checkReset(s);
        clear_n = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] single write, 1 wait state");
        applyStimulus(1, 1'b1, 1'b1, 32'h0000_0014, 1, 1'b0, 32'hA5A5_1234, 4'b0000);
        checkOutput("write_addr", 32'(obs_addr[1]), 32'd5);
        checkOutput("write_data", obs_wdata[1], 32'hA5A5_1234);
        checkOutput("write_be", 32'(obs_be[1]), 32'hF);

        $display("[TB] single read, 0 wait states");
        applyStimulus(0, 1'b0, 1'b1, 32'h0000_0008, 1, 1'b0, 32'h1111_2222, 4'b0101);
        checkOutput("read_addr", 32'(obs_addr[0]), 32'd2);

        $display("[TB] burst write across address wrap");
        applyStimulus(0, 1'b1, 1'b1, 32'h0000_01F8, 4, 1'b0, 32'h0BAD_F00D, 4'b1100);
        checkOutput("burst_final_addr", 32'(obs_addr[0]), 32'd1);

        $display("[TB] ADS without chip select");
        applyStimulus(1, 1'b1, 1'b0, 32'h0000_0040, 1, 1'b0, 32'hDEAD_BEEF, 4'b0000);

        $display("[TB] stray ADS during wait states");
        applyStimulus(2, 1'b0, 1'b1, 32'h0000_0030, 1, 1'b1, 32'h0, 4'b0011);
        checkOutput("stray_addr", 32'(obs_addr[2]), 32'd12);

        $display("[TB] reset in the middle of a burst");
        sel  = 1;
        ads  = 1'b0;
        cs0  = 1'b1;
        lw_r = 1'b0;
        lad  = 32'h0000_0100;
        @(posedge clk);
        #1;
        ads = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("pre_reset_rd", 32'(obs_rd[1]), 32'd1);
        clear_n = 1'b0;
        @(posedge clk);
        #1;
        clearModel();
        checkReset(1);
        @(posedge clk);
        #1;
        checkReset(1);
        clear_n = 1'b1;
        cs0     = 1'b0;

        $display("[TB] randomized bursts");
        for (int k = 0; k < 12; k++) begin
            rs  = $urandom_range(0, 2);
            rwr = 1'($urandom);
            rn  = $urandom_range(1, 4);
            applyStimulus(rs, rwr, 1'b1, $urandom, rn, 1'b0, $urandom, 4'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
